// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the N-digit BCD counter.
// Digit width and per-digit clamping used on parallel load.
package bcd_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  function automatic bcd_digit_t clamp_digit(
    input bcd_digit_t d,
    input bcd_digit_t max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with step, load and clear.
// Wraps 0..DIGIT_MAX in either direction on an enabled step.
module bcd_digit_cell
  import bcd_counter_pkg::*;
#(
  parameter int DIGIT_MAX = 9
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       step,
  input  logic       up_dn,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       sclr,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_zero
);

  localparam bcd_digit_t MAXD = bcd_digit_t'(DIGIT_MAX);

  assign at_max  = (digit == MAXD);
  assign at_zero = (digit == '0);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      digit <= '0;
    end else if (sclr) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_d, MAXD);
    end else if (step) begin
      if (up_dn)
        digit <= at_max ? '0 : digit + 1'b1;
      else
        digit <= at_zero ? MAXD : digit - 1'b1;
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Parametrised N-digit BCD up/down counter with cascade output.
// Digit steps are gated by AND-chains of the lower digits' limits.
module bcd_counter_ndigit
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    sclr,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                    carry_out,
  output logic                    tc_out
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   max_chain;
  logic [DIGITS:0]   zero_chain;

  assign max_chain[0]  = 1'b1;
  assign zero_chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign max_chain[i+1]  = max_chain[i] & at_max[i];
    assign zero_chain[i+1] = zero_chain[i] & at_zero[i];
    assign step[i] = en & (up_dn ? max_chain[i] : zero_chain[i]);

    bcd_digit_cell #(
      .DIGIT_MAX(DIGIT_MAX)
    ) u_cell (
      .clk    (clk),
      .clear  (clear),
      .step   (step[i]),
      .up_dn  (up_dn),
      .load   (load),
      .load_d (load_val[DIGIT_W*i +: DIGIT_W]),
      .sclr   (sclr),
      .digit  (count[DIGIT_W*i +: DIGIT_W]),
      .at_max (at_max[i]),
      .at_zero(at_zero[i])
    );
  end

  assign tc_out = en & (up_dn ? max_chain[DIGITS]
                              : zero_chain[DIGITS]);

  // A wrap happens exactly on a step taken at terminal count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      carry_out <= 1'b0;
    else if (sclr || load)
      carry_out <= 1'b0;
    else
      carry_out <= tc_out;
  end

endmodule
